// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder: receiver side of the VGA timing interface.
// Recovers pixel coordinates and blanking from active-low hsync/vsync,
// verifies line and frame periods, and reports lock and timing errors.
// Optional statistics counters are enabled by defining VGA_DECODE_STATS_EN;
// without it frame_count and err_count are tied to zero.
module vga_timing_decoder #(
  parameter logic [9:0] HACTIVE    = 10'd640,
  parameter logic [9:0] HFP        = 10'd16,
  parameter logic [9:0] HSYN       = 10'd96,
  parameter logic [9:0] HBP        = 10'd48,
  parameter logic [9:0] VACTIVE    = 10'd480,
  parameter logic [9:0] VFP        = 10'd11,
  parameter logic [9:0] VSYN       = 10'd2,
  parameter logic [9:0] VBP        = 10'd32,
  parameter int         LOCK_LINES = 4
) (
  input  logic        vgaclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        blank_b,
  output logic        locked,
  output logic        frame_start,
  output logic        timing_err,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  localparam logic [9:0]  HMAX      = HACTIVE + HFP + HSYN + HBP;
  localparam logic [9:0]  VMAX      = VACTIVE + VFP + VSYN + VBP;
  localparam logic [9:0]  HFALL_X   = HACTIVE + HFP;
  localparam logic [9:0]  VFALL_Y   = VACTIVE + VFP;
  localparam logic [10:0] HPER_GOOD = {1'b0, HMAX};
  localparam logic [10:0] HPER_MISS = {1'b0, HMAX} + 11'd1;
  localparam logic [7:0]  LOCK_N    = 8'(LOCK_LINES);

  typedef enum logic [2:0] {
    IDLE,
    HCHK,
    VWAIT,
    FCHK,
    LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [10:0] hper_q, hper_d;
  logic [9:0]  lcnt_q, lcnt_d;
  logic [7:0]  good_q, good_d;
  logic        locked_q, locked_d;
  logic        frame_start_q, frame_start_d;
  logic        timing_err_q, timing_err_d;

  logic hfall, vfall, wrap;
  logic line_bad, line_miss, line_fault, frame_bad;

  // Edge detection, coordinate recovery and period counters
  always_comb begin
    hs_d   = hsync;
    vs_d   = vsync;
    hfall  = hs_q & ~hsync;
    vfall  = vs_q & ~vsync;
    x_d    = x_q + 10'd1;
    y_d    = y_q;
    wrap   = 1'b0;
    hper_d = hper_q;
    lcnt_d = lcnt_q;

    // hsync falls at the first sync pixel of a line; snap x there
    if (hfall) begin
      x_d = HFALL_X;
    end else if (x_q == HMAX - 10'd1) begin
      x_d  = 10'd0;
      wrap = 1'b1;
    end

    // vsync falls on the first sync line; it overrides the line increment
    if (vfall) begin
      y_d = VFALL_Y;
    end else if (wrap) begin
      y_d = (y_q == VMAX - 10'd1) ? 10'd0 : y_q + 10'd1;
    end

    if (hfall) begin
      hper_d = 11'd1;
    end else if (hper_q != 11'h7ff) begin
      hper_d = hper_q + 11'd1;
    end

    // A line starting in the same cycle as vfall belongs to the new frame
    if (vfall) begin
      lcnt_d = {9'd0, hfall};
    end else if (hfall && lcnt_q != 10'h3ff) begin
      lcnt_d = lcnt_q + 10'd1;
    end

    line_bad   = hfall & (hper_q != HPER_GOOD);
    line_miss  = ~hfall & (hper_q == HPER_MISS);
    line_fault = line_bad | line_miss;
    frame_bad  = vfall & (lcnt_q != VMAX);
  end

  // Lock acquisition FSM: next state and registered pulse outputs
  always_comb begin
    state_d      = state_q;
    good_d       = good_q;
    timing_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hfall) begin
          state_d = HCHK;
          good_d  = 8'd0;
        end
      end
      HCHK: begin
        if (hfall && !line_bad) begin
          good_d = good_q + 8'd1;
          if (good_q + 8'd1 == LOCK_N) state_d = VWAIT;
        end else if (line_fault) begin
          good_d = 8'd0;
        end
      end
      VWAIT: begin
        if (line_fault)  state_d = IDLE;
        else if (vfall)  state_d = FCHK;
      end
      FCHK: begin
        if (line_fault) state_d = IDLE;
        else if (vfall) state_d = frame_bad ? VWAIT : LOCKED;
      end
      LOCKED: begin
        if (line_fault || frame_bad) begin
          state_d      = IDLE;
          timing_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    locked_d      = (state_d == LOCKED);
    frame_start_d = locked_d & (x_d == 10'd0) & (y_d == 10'd0);
  end

  // State and datapath registers
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hper_q        <= 11'd0;
      lcnt_q        <= 10'd0;
      good_q        <= 8'd0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hper_q        <= hper_d;
      lcnt_q        <= lcnt_d;
      good_q        <= good_d;
      locked_q      <= locked_d;
      frame_start_q <= frame_start_d;
      timing_err_q  <= timing_err_d;
    end
  end

`ifdef VGA_DECODE_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] err_count_q, err_count_d;

  // Saturating event counters, cleared only by reset
  always_comb begin
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    if (frame_start_q && frame_count_q != 16'hffff) frame_count_d = frame_count_q + 16'd1;
    if (timing_err_q && err_count_q != 16'hffff)    err_count_d   = err_count_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      frame_count_q <= 16'd0;
      err_count_q   <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`else
  assign frame_count = 16'd0;
  assign err_count   = 16'd0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign timing_err  = timing_err_q;
  assign blank_b     = locked_q & (x_q < HACTIVE) & (y_q < VACTIVE);

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Testbench for vga_timing_decoder: a randomized sync source with injected
// line, sync and frame faults, compared every cycle against an event-level
// reference model. Uses a reduced raster so many frames fit in a short run.
module tb_vga_timing_decoder;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 12, VF = 2, VS = 2, VB = 4;
  localparam int LOCKN = 4;
  localparam int HMAX = HA + HF + HS + HB;   // 32
  localparam int VMAX = VA + VF + VS + VB;   // 20
  localparam int NCYC = 60 * HMAX * VMAX;
  localparam int RST_AT = 20000;

  logic        vgaclk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [9:0]  x, y;
  logic        blank_b, locked, frame_start, timing_err;
  logic [15:0] frame_count, err_count;

  int n_tests = 0;
  int n_fail  = 0;

  vga_timing_decoder #(
    .HACTIVE(10'(HA)), .HFP(10'(HF)), .HSYN(10'(HS)), .HBP(10'(HB)),
    .VACTIVE(10'(VA)), .VFP(10'(VF)), .VSYN(10'(VS)), .VBP(10'(VB)),
    .LOCK_LINES(LOCKN)
  ) dut (
    .vgaclk(vgaclk), .reset(reset), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .blank_b(blank_b), .locked(locked),
    .frame_start(frame_start), .timing_err(timing_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 vgaclk = ~vgaclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  int m_n, m_last_h, m_lines, m_x, m_y, m_good, m_varm;
  bit m_hs_prev, m_vs_prev, m_track, m_lock;
  int e_blank, e_locked, e_fs, e_terr, e_fc, e_ec;

  task automatic model_reset();
    m_n = 0; m_last_h = -1; m_lines = 0; m_x = 0; m_y = 0;
    m_good = 0; m_varm = 0; m_hs_prev = 1; m_vs_prev = 1;
    m_track = 0; m_lock = 0;
    e_blank = 0; e_locked = 0; e_fs = 0; e_terr = 0; e_fc = 0; e_ec = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs);
    bit hf, vf, lbad, miss, fbad, wrap;
    int per, cnt;
    m_n++;
    hf   = m_hs_prev && !hs;
    vf   = m_vs_prev && !vs;
    per  = (m_last_h < 0) ? m_n - 1 : m_n - m_last_h;
    lbad = hf && (per != HMAX);
    miss = !hf && (m_last_h >= 0) && (per == HMAX + 1);
    cnt  = (m_lines > 1023) ? 1023 : m_lines;
    fbad = vf && (cnt != VMAX);

`ifdef VGA_DECODE_STATS_EN
    if (e_fs != 0 && e_fc < 65535) e_fc++;
    if (e_terr != 0 && e_ec < 65535) e_ec++;
`endif

    e_terr = 0;
    if (m_lock) begin
      if (lbad || miss || fbad) begin
        e_terr = 1; m_lock = 0; m_track = 0;
      end
    end else if (!m_track) begin
      if (hf) begin m_track = 1; m_good = 0; m_varm = 0; end
    end else if (m_good < LOCKN) begin
      if (hf && !lbad) m_good++;
      else if (lbad || miss) m_good = 0;
    end else begin
      if (lbad || miss) m_track = 0;
      else if (vf) begin
        if (m_varm == 0) m_varm = 1;
        else if (!fbad) m_lock = 1;
        else m_varm = 0;
      end
    end

    wrap = !hf && (m_x == HMAX - 1);
    if (hf) m_last_h = m_n;
    m_x = (m_last_h < 0) ? (m_n % HMAX) : ((HA + HF + m_n - m_last_h) % HMAX);
    if (vf) m_y = VA + VF;
    else if (wrap) m_y = (m_y + 1) % VMAX;

    if (vf) m_lines = hf ? 1 : 0;
    else if (hf) m_lines++;

    e_locked = m_lock;
    e_fs     = (m_lock && m_x == 0 && m_y == 0) ? 1 : 0;
    e_blank  = (m_lock && m_x < HA && m_y < VA) ? 1 : 0;
    m_hs_prev = hs;
    m_vs_prev = vs;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, "x"}, 32'(x), 32'(m_x));
    chk({pfx, "y"}, 32'(y), 32'(m_y));
    chk({pfx, "blank_b"}, 32'(blank_b), 32'(e_blank));
    chk({pfx, "locked"}, 32'(locked), 32'(e_locked));
    chk({pfx, "frame_start"}, 32'(frame_start), 32'(e_fs));
    chk({pfx, "timing_err"}, 32'(timing_err), 32'(e_terr));
    chk({pfx, "frame_count"}, 32'(frame_count), 32'(e_fc));
    chk({pfx, "err_count"}, 32'(err_count), 32'(e_ec));
  endtask

  // ---------------- sync source ----------------
  int sx, sy, line_len, frame_lines, nohs;
  bit faults_on;

  task automatic new_line();
    int r;
    line_len = HMAX;
    if (nohs > 0) nohs--;
    if (faults_on) begin
      r = $urandom_range(0, 99);
      if (r < 2) line_len = HMAX - 1;
      else if (r < 4) line_len = HMAX + 1;
      else if (r < 6 && nohs == 0) nohs = $urandom_range(1, 3);
    end
  endtask

  task automatic drive_src();
    hsync = !(nohs == 0 && sx >= HA + HF && sx < HA + HF + HS);
    vsync = !(sy >= VA + VF && sy < VA + VF + VS);
  endtask

  task automatic advance_src();
    if (sx >= line_len - 1) begin
      sx = 0;
      if (sy >= frame_lines - 1) begin
        sy = 0;
        frame_lines = (faults_on && $urandom_range(0, 99) < 15) ? VMAX - 1 : VMAX;
      end else begin
        sy++;
      end
      new_line();
    end else begin
      sx++;
    end
  endtask

  int lock_cycles = 0;
  int fs_pulses = 0;
  bit in_reset;

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1;
    model_reset();
    repeat (2) @(posedge vgaclk);
    @(negedge vgaclk);
    check_all("rst_");
    @(posedge vgaclk); #1;
    reset = 1'b0;
    in_reset = 0;
    sx = 0; sy = 0; line_len = HMAX; frame_lines = VMAX; nohs = 0; faults_on = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      drive_src();
      @(posedge vgaclk); #1;
      if (in_reset) model_reset();
      else model_step(hsync, vsync);
      check_all("");
      if (locked === 1'b1) lock_cycles++;
      if (frame_start === 1'b1) fs_pulses++;
      faults_on = (cyc > 3 * HMAX * VMAX);
      advance_src();
      if (cyc == RST_AT) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst_");
        in_reset = 1;
      end else if (cyc == RST_AT + 3) begin
        reset = 1'b0;
        in_reset = 0;
      end
    end

    chk("lock_reached", 32'(lock_cycles > 0), 32'd1);
    chk("frame_start_seen", 32'(fs_pulses > 0), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
- Receiver side of the VGA timing interface.
- Monitors incoming active-low hsync/vsync and recovers the pixel coordinate (x, y) and blanking.
- Verifies line/frame periods against the expected 640x480 timing and reports lock and timing errors.
- Used downstream of a sync source (capture path, or loopback checker on our own timing generator) to drive pixel-consuming logic with regenerated coordinates.

Parameters:
- HACTIVE, 10'd640, visible pixels per line
- HFP, 10'd16, horizontal front porch
- HSYN, 10'd96, hsync pulse width
- HBP, 10'd48, horizontal back porch
- VACTIVE, 10'd480, visible lines
- VFP, 10'd11, vertical front porch
- VSYN, 10'd2, vsync pulse width
- VBP, 10'd32, vertical back porch
- LOCK_LINES, 4, consecutive correct line periods required before frame check
- Derived, not overridable: HMAX = 800, VMAX = 525.

Ports:
- vgaclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hsync  in  1  active-low horizontal sync, synchronous to vgaclk
- vsync  in  1  active-low vertical sync, synchronous to vgaclk
- x  out  10  recovered column
- y  out  10  recovered row
- blank_b  out  1  high when locked and in the active region
- locked  out  1  timing verified
- frame_start  out  1  one-cycle pulse when x==0, y==0 while locked
- timing_err  out  1  one-cycle pulse on any period violation
- frame_count  out  16  frames seen while locked (optional feature)
- err_count  out  16  timing_err pulses (optional feature)

Behaviour:
- Reset (asynchronous): all outputs 0; state IDLE; hs_q = vs_q = 1; all counters 0.
- Edge detect:
  - hs_q and vs_q are the previous-cycle samples of hsync and vsync.
  - hfall = hs_q & ~hsync; vfall = vs_q & ~vsync.
- x/y recovery (latency 1: decoder x/y equal the source x/y one cycle earlier):
  - hfall: x <= HACTIVE+HFP (656).
  - Otherwise x <= x+1; x == HMAX-1 wraps to 0 and y <= y+1.
  - y == VMAX-1 at wrap gives y <= 0.
  - vfall: y <= VACTIVE+VFP (491). This overrides the increment; x still wraps/increments normally.
  - Recovery runs in every state, including before lock.
- hper: 11-bit cycle counter since the last hfall. Cleared to 1 on hfall; saturates at 2047.
- lcnt: 10-bit count of hfall since the last vfall. Cleared to 0 on vfall; vfall and hfall in the same cycle give lcnt = 1.
- Line check:
  - At hfall, good line iff hper == HMAX.
  - hper reaching HMAX+1 with no hfall is a missing-sync violation.
- Frame check: at vfall, good frame iff lcnt == VMAX.
- FSM:
  - IDLE: first hfall -> HCHK, good-line count = 0.
  - HCHK: good line increments the count; bad line or missing sync resets it to 0 (no timing_err). Count reaching LOCK_LINES -> VWAIT.
  - VWAIT: vfall -> FCHK. Bad line or missing sync -> IDLE.
  - FCHK: vfall with good frame -> LOCKED; bad frame -> VWAIT. Bad line or missing sync -> IDLE.
  - LOCKED: bad line, missing sync, or bad frame -> timing_err pulse for 1 cycle, then IDLE.
- locked is registered: high exactly in LOCKED, and drops the cycle after the violating edge.
- blank_b = locked & (x < HACTIVE) & (y < VACTIVE). This output is combinational from registers.
- frame_start is registered; it pulses the cycle x becomes 0 with y becoming 0, only while locked.
- Sync pulse widths are not checked; only falling-edge periods are checked.

Optional Feature:
- VGA_DECODE_STATS_EN defined:
  - frame_count increments on each frame_start.
  - err_count increments on each timing_err.
  - Both saturate at 16'hFFFF and clear only on reset.
- Undefined: frame_count and err_count are tied to 0; the ports remain present.

Test Plan:
- Nominal 800x525 timing from reset, same reset as the source:
  - locked rises after the 2nd vfall (frame 2, y=491).
  - Thereafter x/y equal the source x/y delayed 1 cycle every cycle.
  - blank_b matches the source blank_b delayed 1.
- Locked stream, one line shortened to 799 cycles:
  - timing_err 1-cycle pulse at that hfall; locked = 0 next cycle.
  - Relock after LOCK_LINES good lines plus 2 vfalls.
- Locked stream, hsync held high:
  - At hper == 801, timing_err pulses and locked falls.
  - x keeps free-running and wrapping 799 -> 0.
- Frame of 524 lines:
  - timing_err at that vfall; y forced to 491 there.
  - After recovery, frame_start pulses once per 420000 cycles.
- reset asserted mid-frame while locked:
  - All outputs 0 asynchronously; no timing_err pulse.
  - Lock reacquired from IDLE after release.
- VGA_DECODE_STATS_EN defined, 3 good frames then 2 injected errors:
  - frame_count == 3 (counting from lock), err_count == 2.
  - With the macro undefined, both read 0.
